// File: rtl/fp_divsqrt_arb.sv
// Two-requester round-robin sequencer in front of one shared iterative fp_div and fp_sqrt.
// Issues one operation at a time, waits for the matching done (or a watchdog abort), returns the result.
module fp_divsqrt_arb #(
  parameter int FP_WIDTH = 32,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [2*FP_WIDTH-1:0] req_a_i,
  input  logic [2*FP_WIDTH-1:0] req_b_i,
  input  logic [5:0]            req_rnd_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [FP_WIDTH-1:0]   rsp_result_o,
  output logic [4:0]            rsp_flags_o,
  output logic                  rsp_timeout_o,
  output logic                  div_start_o,
  output logic                  sqrt_start_o,
  output logic [FP_WIDTH-1:0]   unit_a_o,
  output logic [FP_WIDTH-1:0]   unit_b_o,
  output logic [2:0]            unit_rnd_o,
  input  logic                  div_done_i,
  input  logic                  sqrt_done_i,
  input  logic [FP_WIDTH-1:0]   unit_result_i,
  input  logic [4:0]            unit_flags_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP
  } state_e;

  localparam int                 CW           = $clog2(TIMEOUT);
  localparam logic [CW-1:0]      WD_LIMIT     = CW'(TIMEOUT - 1);
  localparam logic [FP_WIDTH-1:0] ABORT_RESULT = FP_WIDTH'(32'h7FC0_0000);
  localparam logic [4:0]         ABORT_FLAGS  = 5'b10000;

  state_e        state_q, state_d;
  logic          rr_ptr;
  logic          owner;
  logic          op_q;
  logic [CW-1:0] wd_cnt;

  logic grant;
  logic unit_done;
  logic accept, capture_done, capture_abort, release_rsp, wd_clear, wd_inc;

  // The pointed-to requester wins a tie; otherwise the only valid one is taken.
  assign grant     = req_valid_i[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign unit_done = op_q ? sqrt_done_i : div_done_i;
  assign busy_o    = (state_q != S_IDLE);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    req_ready_o   = 2'b00;
    rsp_valid_o   = 2'b00;
    div_start_o   = 1'b0;
    sqrt_start_o  = 1'b0;
    accept        = 1'b0;
    capture_done  = 1'b0;
    capture_abort = 1'b0;
    release_rsp   = 1'b0;
    wd_clear      = 1'b0;
    wd_inc        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          req_ready_o = grant ? 2'b10 : 2'b01;
          accept      = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start_o  = ~op_q;
        sqrt_start_o = op_q;
        wd_clear     = 1'b1;
        state_d      = S_BUSY;
      end
      S_BUSY: begin
        // A done arriving on the limit cycle still counts as a normal completion.
        if (unit_done) begin
          capture_done = 1'b1;
          state_d      = S_RESP;
        end else if (wd_cnt == WD_LIMIT) begin
          capture_abort = 1'b1;
          state_d       = S_RESP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_o = owner ? 2'b10 : 2'b01;
        if (rsp_ready_i[owner]) begin
          release_rsp = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the operand and response registers are reset too, because they drive module outputs that must read 0.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      op_q          <= 1'b0;
      wd_cnt        <= '0;
      unit_a_o      <= '0;
      unit_b_o      <= '0;
      unit_rnd_o    <= '0;
      rsp_result_o  <= '0;
      rsp_flags_o   <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner      <= grant;
        op_q       <= req_op_i[grant];
        unit_a_o   <= grant ? req_a_i[2*FP_WIDTH-1:FP_WIDTH] : req_a_i[FP_WIDTH-1:0];
        unit_b_o   <= grant ? req_b_i[2*FP_WIDTH-1:FP_WIDTH] : req_b_i[FP_WIDTH-1:0];
        unit_rnd_o <= grant ? req_rnd_i[5:3] : req_rnd_i[2:0];
      end
      if (wd_clear) begin
        wd_cnt <= '0;
      end else if (wd_inc) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (capture_done) begin
        rsp_result_o  <= unit_result_i;
        rsp_flags_o   <= unit_flags_i;
        rsp_timeout_o <= 1'b0;
      end else if (capture_abort) begin
        rsp_result_o  <= ABORT_RESULT;
        rsp_flags_o   <= ABORT_FLAGS;
        rsp_timeout_o <= 1'b1;
      end
      if (release_rsp) begin
        rr_ptr <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_arb.sv
// Self-checking bench for fp_divsqrt_arb: the bench plays both requesters and the shared units,
// predicting grants from a round-robin model and responses from the values it fed the units.
module tb_fp_divsqrt_arb;

  localparam int W  = 32;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [1:0]     req_valid_i;
  logic [1:0]     req_ready_o;
  logic [1:0]     req_op_i;
  logic [2*W-1:0] req_a_i;
  logic [2*W-1:0] req_b_i;
  logic [5:0]     req_rnd_i;
  logic [1:0]     rsp_valid_o;
  logic [1:0]     rsp_ready_i;
  logic [W-1:0]   rsp_result_o;
  logic [4:0]     rsp_flags_o;
  logic           rsp_timeout_o;
  logic           div_start_o;
  logic           sqrt_start_o;
  logic [W-1:0]   unit_a_o;
  logic [W-1:0]   unit_b_o;
  logic [2:0]     unit_rnd_o;
  logic           div_done_i;
  logic           sqrt_done_i;
  logic [W-1:0]   unit_result_i;
  logic [4:0]     unit_flags_i;
  logic           busy_o;

  int checks = 0;
  int passed = 0;
  int rr_model = 0;

  always #5 clk = ~clk;

  fp_divsqrt_arb #(.FP_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rnd_i(req_rnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_flags_o(rsp_flags_o), .rsp_timeout_o(rsp_timeout_o),
    .div_start_o(div_start_o), .sqrt_start_o(sqrt_start_o),
    .unit_a_o(unit_a_o), .unit_b_o(unit_b_o), .unit_rnd_o(unit_rnd_o),
    .div_done_i(div_done_i), .sqrt_done_i(sqrt_done_i),
    .unit_result_i(unit_result_i), .unit_flags_i(unit_flags_i), .busy_o(busy_o)
  );

  // Round-robin rule: the favoured requester wins if it asks, otherwise whoever asks.
  function automatic int model_grant(input logic [1:0] v);
    if (v[rr_model]) return rr_model;
    return 1 - rr_model;
  endfunction

  function automatic logic [2*W+4+W+5+1+2+2*W+3+1-1:0] all_outputs();
    return {req_ready_o, rsp_valid_o, rsp_result_o, rsp_flags_o, rsp_timeout_o,
            div_start_o, sqrt_start_o, unit_a_o, unit_b_o, unit_rnd_o, busy_o};
  endfunction

  // One full transaction. Caller drives the request inputs just after a falling edge.
  // delay = BUSY cycles until the unit done (done asserted on the delay-th BUSY cycle);
  // to = unit never finishes; hold = cycles the owner stalls the response.
  task automatic run_txn(input int delay, input logic [W-1:0] res, input logic [4:0] flg,
                         input int hold, input bit spur, input bit to, output int g);
    logic         op;
    logic [W-1:0] ea, eb, exp_res;
    logic [2:0]   er;
    logic [4:0]   exp_flg;
    logic         exp_to;
    logic [1:0]   exp_valid;
    bit           early, bad;
    int           n;
    #1;
    g = model_grant(req_valid_i);
    exp_valid = (g == 1) ? 2'b10 : 2'b01;
    checks++;
    if (req_ready_o !== exp_valid) $display("FAIL grant: req_ready_o=%b expected %b", req_ready_o, exp_valid);
    else passed++;
    op = req_op_i[g];
    ea = (g == 1) ? req_a_i[2*W-1:W] : req_a_i[W-1:0];
    eb = (g == 1) ? req_b_i[2*W-1:W] : req_b_i[W-1:0];
    er = (g == 1) ? req_rnd_i[5:3] : req_rnd_i[2:0];

    @(negedge clk);
    req_valid_i[g] = 1'b0;
    #1;
    checks++;
    if ({div_start_o, sqrt_start_o} !== (op ? 2'b01 : 2'b10) || busy_o !== 1'b1)
      $display("FAIL issue: div_start=%b sqrt_start=%b busy=%b op=%b", div_start_o, sqrt_start_o, busy_o, op);
    else passed++;
    checks++;
    if ({unit_a_o, unit_b_o, unit_rnd_o} !== {ea, eb, er})
      $display("FAIL operands: a=%h b=%h rnd=%0d expected a=%h b=%h rnd=%0d", unit_a_o, unit_b_o, unit_rnd_o, ea, eb, er);
    else passed++;

    if (to) begin
      n = 0;
      while (rsp_valid_o === 2'b00 && n < 200) begin
        @(negedge clk);
        n++;
        #1;
      end
      checks++;
      if (n != TO + 1) $display("FAIL timeout_latency: response %0d cycles after issue, expected %0d", n, TO + 1);
      else passed++;
      exp_res = 32'h7FC0_0000; exp_flg = 5'b10000; exp_to = 1'b1;
    end else begin
      early = 1'b0;
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk);
        div_done_i = 1'b0; sqrt_done_i = 1'b0;
        if (k == delay) begin
          if (op) sqrt_done_i = 1'b1; else div_done_i = 1'b1;
          unit_result_i = res; unit_flags_i = flg;
        end else if (spur && k == 1) begin
          if (op) div_done_i = 1'b1; else sqrt_done_i = 1'b1;
        end
        #1;
        if (rsp_valid_o !== 2'b00 || div_start_o !== 1'b0 || sqrt_start_o !== 1'b0) early = 1'b1;
      end
      @(negedge clk);
      div_done_i = 1'b0; sqrt_done_i = 1'b0;
      unit_result_i = ~res; unit_flags_i = ~flg;
      #1;
      checks++;
      if (early) $display("FAIL busy_quiet: response or start seen before the owning unit's done");
      else passed++;
      exp_res = res; exp_flg = flg; exp_to = 1'b0;
    end

    checks++;
    if (rsp_valid_o !== exp_valid) $display("FAIL rsp_valid: %b expected %b", rsp_valid_o, exp_valid);
    else passed++;
    checks++;
    if ({rsp_result_o, rsp_flags_o, rsp_timeout_o} !== {exp_res, exp_flg, exp_to})
      $display("FAIL rsp_data: result=%h flags=%b timeout=%b expected %h %b %b",
               rsp_result_o, rsp_flags_o, rsp_timeout_o, exp_res, exp_flg, exp_to);
    else passed++;

    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rsp_ready_i = (g == 1) ? 2'b01 : 2'b10;
      div_done_i = 1'b1; sqrt_done_i = 1'b1;
      #1;
      if (rsp_valid_o !== exp_valid || rsp_result_o !== exp_res || rsp_flags_o !== exp_flg ||
          rsp_timeout_o !== exp_to || req_ready_o !== 2'b00 || unit_a_o !== ea || unit_b_o !== eb)
        bad = 1'b1;
    end
    if (hold > 0) begin
      checks++;
      if (bad) $display("FAIL stall: response changed or a request was accepted while stalled (valid=%b ready=%b)",
                        rsp_valid_o, req_ready_o);
      else passed++;
    end

    @(negedge clk);
    div_done_i = 1'b0; sqrt_done_i = 1'b0;
    rsp_ready_i = exp_valid;
    @(negedge clk);
    rsp_ready_i = 2'b00;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0)
      $display("FAIL release: rsp_valid=%b busy=%b expected 00 0", rsp_valid_o, busy_o);
    else passed++;
    rr_model = 1 - g;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_a_i = '0; req_b_i = '0; req_rnd_i = '0;
    rsp_ready_i = '0; div_done_i = 1'b0; sqrt_done_i = 1'b0;
    unit_result_i = '0; unit_flags_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) $display("FAIL reset_outputs: %h expected all zero", all_outputs());
    else passed++;
    @(negedge clk);
    reset_i = 1'b1;
    rr_model = 0;
  endtask

  task automatic test_single_div();
    int g;
    @(negedge clk);
    req_valid_i = 2'b01; req_op_i = 2'b00;
    req_a_i = {32'h1111_1111, 32'h3F80_0000};
    req_b_i = {32'h2222_2222, 32'h4000_0000};
    req_rnd_i = 6'b101_000;
    run_txn(10, 32'h3F00_0000, 5'b00000, 0, 1'b0, 1'b0, g);
  endtask

  task automatic test_sqrt();
    int g;
    req_valid_i = 2'b10; req_op_i = 2'b10;
    req_a_i = {32'h4080_0000, 32'h3F80_0000};
    req_b_i = {32'hDEAD_BEEF, 32'h0};
    req_rnd_i = 6'b011_001;
    run_txn(7, 32'h4000_0000, 5'b00000, 0, 1'b0, 1'b0, g);
  endtask

  task automatic test_back_to_back();
    int g;
    logic [1:0] seen;
    rr_model = 0;
    // Reset so the round-robin pointer starts from requester 0.
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk); reset_i = 1'b1;
    req_valid_i = 2'b11; req_op_i = 2'b00;
    req_a_i = {32'h4040_0000, 32'h40A0_0000};
    req_b_i = {32'h3F80_0000, 32'h4000_0000};
    req_rnd_i = 6'b000_000;
    for (int i = 0; i < 4; i++) begin
      run_txn(3 + i, 32'h1000_0000 + i, 5'(i), 0, 1'b0, 1'b0, g);
      seen = (g == 1) ? 2'b10 : 2'b01;
      checks++;
      if (seen !== ((i % 2 == 1) ? 2'b10 : 2'b01))
        $display("FAIL alternate: txn %0d granted %b", i, seen);
      else passed++;
      req_valid_i = 2'b11;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_timeout();
    int g;
    req_valid_i = 2'b01; req_op_i = 2'b00;
    req_a_i = {32'h0, 32'h4120_0000}; req_b_i = {32'h0, 32'h4100_0000}; req_rnd_i = 6'b000_010;
    run_txn(0, 32'h0, 5'b0, 0, 1'b0, 1'b1, g);
  endtask

  task automatic test_done_at_limit();
    int g;
    req_valid_i = 2'b10; req_op_i = 2'b10;
    req_a_i = {32'h4110_0000, 32'h0}; req_b_i = '0; req_rnd_i = 6'b100_000;
    run_txn(TO, 32'h4040_0000, 5'b00001, 0, 1'b0, 1'b0, g);
  endtask

  task automatic test_stall_spurious();
    int g;
    req_valid_i = 2'b11; req_op_i = 2'b00;
    req_a_i = {32'h4200_0000, 32'h4100_0000}; req_b_i = {32'h4000_0000, 32'h4080_0000};
    req_rnd_i = 6'b001_011;
    run_txn(6, 32'h4080_0000, 5'b00001, 5, 1'b1, 1'b0, g);
    req_valid_i = 2'b00;
  endtask

  task automatic test_reset_busy();
    int g;
    @(negedge clk);
    req_valid_i = 2'b01; req_op_i = 2'b00;
    req_a_i = {32'h3F80_0000, 32'h4000_0000}; req_b_i = {32'h0, 32'h4000_0000}; req_rnd_i = '0;
    @(negedge clk);
    req_valid_i = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    reset_i = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== '0) $display("FAIL reset_busy: outputs %h expected all zero", all_outputs());
    else passed++;
    @(negedge clk);
    req_valid_i = 2'b10; req_op_i = 2'b10;
    req_a_i = {32'h4180_0000, 32'h0};
    reset_i = 1'b1;
    rr_model = 0;
    run_txn(5, 32'h4080_0000, 5'b00000, 0, 1'b0, 1'b0, g);
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 20; i++) begin
      req_valid_i = 2'($urandom_range(1, 3));
      req_op_i    = 2'($urandom);
      req_a_i     = {$urandom, $urandom};
      req_b_i     = {$urandom, $urandom};
      req_rnd_i   = 6'($urandom);
      run_txn($urandom_range(1, 30), $urandom, 5'($urandom), $urandom_range(0, 3),
              1'($urandom), 1'b0, g);
    end
    req_valid_i = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: bench did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_div();
    test_sqrt();
    test_back_to_back();
    test_timeout();
    test_done_at_limit();
    test_stall_spurious();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
